// File: rtl/glitch_pkg.sv
// Shared types and sizing for the glitch parameter sweeper.
// Holds the sweep state encoding, datapath widths and default timing limits.
package glitch_pkg;

  localparam int DELAY_W   = 16;
  localparam int WIDTH_W   = 8;
  localparam int ATTEMPT_W = 16;

  localparam int TRIG_TIMEOUT_DEF = 1_000_000;
  localparam int OBS_CYCLES_DEF   = 1024;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RESET     = 4'd1,
    ST_WAIT_RST  = 4'd2,
    ST_ARM       = 4'd3,
    ST_WAIT_FIRE = 4'd4,
    ST_WAIT_END  = 4'd5,
    ST_OBSERVE   = 4'd6,
    ST_STEP      = 4'd7,
    ST_DONE      = 4'd8
  } sweep_state_e;

endpackage

// File: rtl/sweep_stepper.sv
// Range incrementer: next = cur + step (step 0 acts as 1) with one extra carry bit.
// Wraps back to the range start on carry or when the sum passes the range end.
module sweep_stepper
  import glitch_pkg::*;
#(
  parameter int W = WIDTH_W
) (
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] i_step,
  input  logic [W-1:0] i_start,
  input  logic [W-1:0] i_end,
  output logic [W-1:0] o_next,
  output logic         o_wrap
);

  logic [W-1:0] w_step;
  logic [W:0]   w_sum;

  always_comb begin
    w_step = (i_step == '0) ? W'(1) : i_step;
    w_sum  = {1'b0, i_cur} + {1'b0, w_step};
    o_wrap = w_sum[W] || (w_sum[W-1:0] > i_end);
    o_next = o_wrap ? i_start : w_sum[W-1:0];
  end

endmodule

// File: rtl/glitch_sweeper.sv
// Autonomous delay/width sweep controller driving the resetter and pulser.
// Define GLITCH_SWEEP_STOP_ON_HIT_EN to end the sweep at the first recorded hit.
module glitch_sweeper
  import glitch_pkg::*;
#(
  parameter int TRIG_TIMEOUT = TRIG_TIMEOUT_DEF,
  parameter int OBS_CYCLES   = OBS_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [DELAY_W-1:0]   delay_start_i,
  input  logic [DELAY_W-1:0]   delay_end_i,
  input  logic [DELAY_W-1:0]   delay_step_i,
  input  logic [WIDTH_W-1:0]   width_start_i,
  input  logic [WIDTH_W-1:0]   width_end_i,
  input  logic [WIDTH_W-1:0]   width_step_i,
  input  logic                 reset_done_i,
  input  logic                 busy_i,
  input  logic                 success_i,
  output logic [DELAY_W-1:0]   delay_o,
  output logic [WIDTH_W-1:0]   width_o,
  output logic                 reset_en_o,
  output logic                 arm_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic                 hit_o,
  output logic [DELAY_W-1:0]   hit_delay_o,
  output logic [WIDTH_W-1:0]   hit_width_o,
  output logic [ATTEMPT_W-1:0] attempts_o
);

  localparam int TCNT_W = $clog2(TRIG_TIMEOUT + 1);
  localparam int OCNT_W = $clog2(OBS_CYCLES + 1);

`ifdef GLITCH_SWEEP_STOP_ON_HIT_EN
  localparam bit STOP_ON_HIT = 1'b1;
`else
  localparam bit STOP_ON_HIT = 1'b0;
`endif

  sweep_state_e         r_state;
  logic [DELAY_W-1:0]   r_delay;
  logic [WIDTH_W-1:0]   r_width;
  logic                 r_hit;
  logic [DELAY_W-1:0]   r_hit_delay;
  logic [WIDTH_W-1:0]   r_hit_width;
  logic [ATTEMPT_W-1:0] r_attempts;
  logic [TCNT_W-1:0]    r_tcnt;
  logic [OCNT_W-1:0]    r_ocnt;

  logic [DELAY_W-1:0]   w_delay_next;
  logic                 w_delay_wrap;
  logic [WIDTH_W-1:0]   w_width_next;
  logic                 w_width_wrap;
  logic [ATTEMPT_W-1:0] w_attempts_inc;
  logic                 w_first_hit;
  logic                 w_obs_last;
  logic                 w_fire_timeout;

  sweep_stepper #(.W(DELAY_W)) u_delay_step (
    .i_cur   (r_delay),
    .i_step  (delay_step_i),
    .i_start (delay_start_i),
    .i_end   (delay_end_i),
    .o_next  (w_delay_next),
    .o_wrap  (w_delay_wrap)
  );

  sweep_stepper #(.W(WIDTH_W)) u_width_step (
    .i_cur   (r_width),
    .i_step  (width_step_i),
    .i_start (width_start_i),
    .i_end   (width_end_i),
    .o_next  (w_width_next),
    .o_wrap  (w_width_wrap)
  );

  assign w_attempts_inc = (r_attempts == '1) ? r_attempts : r_attempts + ATTEMPT_W'(1);
  assign w_first_hit    = success_i && !r_hit;
  assign w_obs_last     = (r_ocnt == OCNT_W'(OBS_CYCLES - 1));
  assign w_fire_timeout = (r_tcnt == TCNT_W'(TRIG_TIMEOUT - 1));

  // Stop beats every other input, including a simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_delay     <= '0;
      r_width     <= '0;
      r_hit       <= 1'b0;
      r_hit_delay <= '0;
      r_hit_width <= '0;
      r_attempts  <= '0;
      r_tcnt      <= '0;
      r_ocnt      <= '0;
    end else if (stop_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_delay     <= delay_start_i;
            r_width     <= width_start_i;
            r_hit       <= 1'b0;
            r_hit_delay <= '0;
            r_hit_width <= '0;
            r_attempts  <= '0;
            r_state     <= ST_RESET;
          end
        end
        ST_RESET:    r_state <= ST_WAIT_RST;
        ST_WAIT_RST: if (reset_done_i) r_state <= ST_ARM;
        ST_ARM: begin
          r_tcnt  <= '0;
          r_state <= ST_WAIT_FIRE;
        end
        ST_WAIT_FIRE: begin
          if (busy_i)              r_state <= ST_WAIT_END;
          else if (w_fire_timeout) r_state <= ST_STEP;
          else                     r_tcnt  <= r_tcnt + TCNT_W'(1);
        end
        ST_WAIT_END: begin
          if (!busy_i) begin
            r_ocnt  <= '0;
            r_state <= ST_OBSERVE;
          end
        end
        ST_OBSERVE: begin
          if (w_first_hit) begin
            r_hit       <= 1'b1;
            r_hit_delay <= r_delay;
            r_hit_width <= r_width;
          end
          if (STOP_ON_HIT && w_first_hit) begin
            r_attempts <= w_attempts_inc;
            r_state    <= ST_DONE;
          end else if (w_obs_last) begin
            r_state <= ST_STEP;
          end else begin
            r_ocnt <= r_ocnt + OCNT_W'(1);
          end
        end
        // Delay is the inner loop; width only moves when delay wraps.
        ST_STEP: begin
          r_attempts <= w_attempts_inc;
          r_delay    <= w_delay_next;
          if (!w_delay_wrap) begin
            r_state <= ST_RESET;
          end else if (w_width_wrap) begin
            r_state <= ST_DONE;
          end else begin
            r_width <= w_width_next;
            r_state <= ST_RESET;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign delay_o     = r_delay;
  assign width_o     = r_width;
  assign reset_en_o  = (r_state == ST_RESET);
  assign arm_o       = (r_state == ST_ARM);
  assign running_o   = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done_o      = (r_state == ST_DONE);
  assign hit_o       = r_hit;
  assign hit_delay_o = r_hit_delay;
  assign hit_width_o = r_hit_width;
  assign attempts_o  = r_attempts;

endmodule

// File: tb/tb_glitch_sweeper.sv
// Directed bench for glitch_sweeper: emulates resetter/pulser/target and checks
// every attempt against a list of (delay, width) pairs built from the range rules.
module tb_glitch_sweeper;

  localparam int TO  = 50;
  localparam int OBS = 8;

`ifdef GLITCH_SWEEP_STOP_ON_HIT_EN
  localparam bit STOP_HIT = 1'b1;
`else
  localparam bit STOP_HIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start_i, stop_i, reset_done_i, busy_i, success_i;
  logic [15:0] delay_start_i, delay_end_i, delay_step_i;
  logic [7:0]  width_start_i, width_end_i, width_step_i;
  logic [15:0] delay_o, hit_delay_o, attempts_o;
  logic [7:0]  width_o, hit_width_o;
  logic        reset_en_o, arm_o, running_o, done_o, hit_o;

  int testsRun = 0;
  int testsFailed = 0;

  int expD[$];
  int expW[$];
  int k = 0;
  bit modelOn = 1'b0;
  bit doneSeen = 1'b0;
  bit expHit = 1'b0;
  int expHitD = 0;
  int expHitW = 0;

  glitch_sweeper #(.TRIG_TIMEOUT(TO), .OBS_CYCLES(OBS)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .delay_start_i(delay_start_i), .delay_end_i(delay_end_i), .delay_step_i(delay_step_i),
    .width_start_i(width_start_i), .width_end_i(width_end_i), .width_step_i(width_step_i),
    .reset_done_i(reset_done_i), .busy_i(busy_i), .success_i(success_i),
    .delay_o(delay_o), .width_o(width_o), .reset_en_o(reset_en_o), .arm_o(arm_o),
    .running_o(running_o), .done_o(done_o), .hit_o(hit_o),
    .hit_delay_o(hit_delay_o), .hit_width_o(hit_width_o), .attempts_o(attempts_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkZeros(input string tag);
    checkOutput({tag, "_delay"}, delay_o, 0);
    checkOutput({tag, "_width"}, width_o, 0);
    checkOutput({tag, "_reset_en"}, reset_en_o, 0);
    checkOutput({tag, "_arm"}, arm_o, 0);
    checkOutput({tag, "_running"}, running_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_hit"}, hit_o, 0);
    checkOutput({tag, "_hit_delay"}, hit_delay_o, 0);
    checkOutput({tag, "_hit_width"}, hit_width_o, 0);
    checkOutput({tag, "_attempts"}, attempts_o, 0);
  endtask

  // Enumerate the attempt order straight from the range rules.
  task automatic buildModel(input int ds, input int de, input int dst,
                            input int ws, input int we, input int wst, input int hitIdx);
    int d, w, sd, sw, nd, nw;
    bit more;
    expD.delete();
    expW.delete();
    d = ds; w = ws;
    sd = (dst == 0) ? 1 : dst;
    sw = (wst == 0) ? 1 : wst;
    more = 1'b1;
    while (more) begin
      expD.push_back(d);
      expW.push_back(w);
      if (STOP_HIT && (expD.size() - 1 == hitIdx)) break;
      nd = d + sd;
      if (nd > de || nd > 65535) begin
        d = ds;
        nw = w + sw;
        if (nw > we || nw > 255) more = 1'b0;
        else w = nw;
      end else begin
        d = nd;
      end
    end
    expHit = (hitIdx >= 0) && (hitIdx < expD.size());
    expHitD = expHit ? expD[hitIdx] : 0;
    expHitW = expHit ? expW[hitIdx] : 0;
  endtask

  task automatic applyStimulus(input int ds, input int de, input int dst,
                               input int ws, input int we, input int wst, input int hitIdx);
    delay_start_i = 16'(ds); delay_end_i = 16'(de); delay_step_i = 16'(dst);
    width_start_i = 8'(ws);  width_end_i = 8'(we);  width_step_i = 8'(wst);
    buildModel(ds, de, dst, ws, we, wst, hitIdx);
    k = 0;
    doneSeen = 1'b0;
    modelOn = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("reset_en_after_start", reset_en_o, 1);
  endtask

  task automatic waitStrobe(input int budget, output int which, output int cyc);
    which = 0;
    cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (reset_en_o) begin which = 1; cyc = c; return; end
      if (done_o)     begin which = 2; cyc = c; return; end
    end
  endtask

  // Entered with reset_en_o high; plays resetter, pulser and target per attempt.
  task automatic runSweep(input bit fire, input int hitA, input int offA, input int hitB,
                          input int abortIdx, input bit abortByRst);
    int which, cyc, idx;
    which = 1;
    idx = 0;
    while (which == 1) begin
      @(negedge clk);
      if (idx == 0) success_i = 1'b1;
      @(negedge clk);
      success_i = 1'b0;
      reset_done_i = 1'b1;
      @(negedge clk);
      reset_done_i = 1'b0;
      checkOutput("arm_after_reset_done", arm_o, 1);
      if (!fire) begin
        waitStrobe(1000, which, cyc);
        checkOutput("fire_timeout_gap", cyc, TO + 2);
      end else begin
        @(negedge clk);
        busy_i = 1'b1;
        repeat (3) @(negedge clk);
        if (idx == abortIdx && !abortByRst) begin
          stop_i = 1'b1;
          start_i = 1'b1;
          @(negedge clk);
          stop_i = 1'b0;
          start_i = 1'b0;
          busy_i = 1'b0;
          checkOutput("stop_running", running_o, 0);
          checkOutput("stop_done", done_o, 0);
          return;
        end
        busy_i = 1'b0;
        if (idx == hitA || idx == hitB) begin
          repeat ((idx == hitA) ? offA : 2) @(negedge clk);
          if (idx == hitA) checkOutput("hit_low_before", hit_o, 0);
          success_i = 1'b1;
          @(negedge clk);
          success_i = 1'b0;
          checkOutput("hit_registered", hit_o, 1);
        end
        if (idx == abortIdx && abortByRst) begin
          repeat (2) @(negedge clk);
          modelOn = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          checkZeros("rst_mid");
          return;
        end
        waitStrobe(1000, which, cyc);
      end
      checkOutput("strobe_seen", which != 0, 1);
      idx++;
    end
  endtask

  // Per-cycle comparison against the attempt list.
  initial begin
    forever begin
      @(negedge clk);
      if (modelOn) begin
        checkOutput("strobe_exclusive", reset_en_o & arm_o, 0);
        if (reset_en_o) begin
          if (k < expD.size()) begin
            checkOutput("attempt_delay", delay_o, expD[k]);
            checkOutput("attempt_width", width_o, expW[k]);
            checkOutput("attempt_index", attempts_o, k);
          end else begin
            checkOutput("extra_attempt", k + 1, expD.size());
          end
          k++;
        end else if (running_o && k > 0 && k <= expD.size()) begin
          checkOutput("held_delay", delay_o, expD[k-1]);
          checkOutput("held_width", width_o, expW[k-1]);
        end
        if (done_o && !doneSeen) begin
          doneSeen = 1'b1;
          checkOutput("done_attempt_count", k, expD.size());
          checkOutput("done_attempts_o", attempts_o, expD.size());
          checkOutput("done_hit", hit_o, expHit);
          if (expHit) begin
            checkOutput("done_hit_delay", hit_delay_o, expHitD);
            checkOutput("done_hit_width", hit_width_o, expHitW);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int strobes;
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    reset_done_i = 1'b0; busy_i = 1'b0; success_i = 1'b0;
    delay_start_i = '0; delay_end_i = '0; delay_step_i = '0;
    width_start_i = '0; width_end_i = '0; width_step_i = '0;
    repeat (3) @(negedge clk);
    checkZeros("por");
    rst = 1'b0;
    @(negedge clk);

    // Plain sweep, every attempt fires, no success.
    applyStimulus(100, 120, 10, 5, 6, 1, -1);
    checkOutput("model_len_a", expD.size(), 6);
    checkOutput("model_d3", expD[3], 100);
    checkOutput("model_w3", expW[3], 6);
    checkOutput("model_d5", expD[5], 120);
    runSweep(1'b1, -1, 0, -1, -1, 1'b0);
    checkOutput("a_done", done_o, 1);
    checkOutput("a_attempts", attempts_o, 6);
    checkOutput("a_hit", hit_o, 0);

    // Hit on the last OBSERVE cycle at (110,6); a later success must not overwrite it.
    applyStimulus(100, 120, 10, 5, 6, 1, 4);
    checkOutput("model_hit_d", expHitD, 110);
    checkOutput("model_hit_w", expHitW, 6);
    runSweep(1'b1, 4, OBS, 5, -1, 1'b0);
    checkOutput("b_done", done_o, 1);
    checkOutput("b_hit", hit_o, 1);
    checkOutput("b_hit_delay", hit_delay_o, 110);
    checkOutput("b_hit_width", hit_width_o, 6);
    checkOutput("b_attempts", attempts_o, STOP_HIT ? 5 : 6);

    // Trigger never fires; delay carry wraps; width step 0 behaves as 1.
    applyStimulus(16'hFFF0, 16'hFFFF, 16'h20, 1, 3, 0, -1);
    checkOutput("model_len_c", expD.size(), 3);
    runSweep(1'b0, -1, 0, -1, -1, 1'b0);
    checkOutput("c_done", done_o, 1);
    checkOutput("c_attempts", attempts_o, 3);
    checkOutput("c_width_last", width_o, 3);

    // start > end on both axes gives one attempt.
    applyStimulus(50, 40, 5, 9, 8, 1, -1);
    runSweep(1'b1, -1, 0, -1, -1, 1'b0);
    checkOutput("d_done", done_o, 1);
    checkOutput("d_attempts", attempts_o, 1);

    // Stop (with simultaneous start) during WAIT_END of attempt 1.
    applyStimulus(100, 120, 10, 5, 6, 1, -1);
    runSweep(1'b1, -1, 0, -1, 1, 1'b0);
    checkOutput("stop_attempts_kept", attempts_o, 1);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (reset_en_o || arm_o) strobes++;
    end
    checkOutput("stop_no_strobes", strobes, 0);
    applyStimulus(100, 120, 10, 5, 6, 1, -1);
    checkOutput("restart_delay", delay_o, 100);
    checkOutput("restart_width", width_o, 5);
    runSweep(1'b1, -1, 0, -1, -1, 1'b0);
    checkOutput("restart_attempts", attempts_o, 6);

    // Reset mid-OBSERVE after a hit has been latched.
    applyStimulus(100, 120, 10, 5, 6, 1, 0);
    runSweep(1'b1, 0, 1, -1, 0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    checkZeros("post_rst");
    applyStimulus(100, 120, 10, 5, 6, 1, -1);
    runSweep(1'b1, -1, 0, -1, -1, 1'b0);
    checkOutput("e_done", done_o, 1);
    checkOutput("e_attempts", attempts_o, 6);
    checkOutput("e_hit", hit_o, 0);

    modelOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
